regfile_exec_ctrl: RTL and testbench
====================================

// Module: regfile_exec_ctrl
// PURPOSE
//  Execution/write-back sequencer that drives the 8x8 register bank's two read ports and its write port.
//  Accepts one instruction per cycle over a valid/ready handshake and reads both operands combinationally.
//  Computes the result in a one-entry EX stage and writes it back one cycle after acceptance.
//  Forwards an EX-stage result to a dependent instruction issued in the next cycle.
//  Provides a multicycle CLR op that zeroes every register through the write port.
// PARAMETERS
//  DW  8  data width; matches register width
//  AW  3  register address width; NREGS = 2**AW
// PORTS
//  clk       in   1   clock; all state updates on posedge
//  reset     in   1   synchronous, active-high reset
//  in_valid  in   1   instruction valid
//  in_ready  out  1   ready to accept an instruction (= !reset && state==RUN)
//  in_op     in   3   0 CLR, 1 LDI, 2 MOV, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR
//  in_rd     in   AW  destination register
//  in_rs1    in   AW  source register A
//  in_rs2    in   AW  source register B
//  in_imm    in   DW  immediate (LDI only)
//  addr_r1   out  AW  bank read address 1 (= in_rs1, combinational)
//  addr_r2   out  AW  bank read address 2 (= in_rs2, combinational)
//  rx        in   DW  bank read data 1
//  ry        in   DW  bank read data 2
//  addr_w    out  AW  bank write address
//  data_w    out  DW  bank write data
//  w_r       out  1   bank write enable; bank writes at posedge when high
//  done      out  1   1-cycle pulse, coincident with an instruction's final write
//  zero      out  1   registered flag: last written result == 0
//  carry     out  1   registered flag: ADD carry-out / SUB borrow
// BEHAVIOUR
//  - States: RUN and CLEAR. Reset gives RUN, ex_v=0, cnt=0, zero=0, carry=0.
//    In that state w_r=0 and done=0; addr_w and data_w are 0.
//  - Accept: in_valid && in_ready at edge N captures op, rd, A and B into the EX regs and sets ex_v=1.
//    If no instruction is accepted, ex_v is 0 after the edge.
//  - Operand forwarding at capture: A = (ex_v && ex_rd==in_rs1) ? ex_res : rx.
//    B uses the same rule with in_rs2 and ry.
//  - RUN write-back during the cycle N..N+1: w_r=ex_v, addr_w=ex_rd, data_w=ex_res, done=ex_v.
//    The bank commits at edge N+1. Latency is 1 cycle, with a throughput of 1 instruction/cycle.
//  - ex_res is computed combinationally from the EX regs, modulo 2**DW:
//    - LDI: imm
//    - MOV: A
//    - ADD: A+B
//    - SUB: A-B
//    - AND / OR / XOR: bitwise on A and B
//  - Flags update at the write-back edge:
//    - zero <= (ex_res==0) for every non-CLR op.
//    - carry <= carry-out of A+B for ADD; carry <= (A<B), unsigned, for SUB.
//    - carry is unchanged for all other ops.
//  - CLR accepted at edge N: state goes to CLEAR, cnt=0, ex_v=0.
//    The pending EX write, if any, still commits at edge N.
//  - CLEAR: in_ready=0, w_r=1, addr_w=cnt, data_w=0. cnt increments each edge.
//    When cnt==NREGS-1: done=1; at that edge go to RUN with cnt=0, zero<=1, carry<=0.
//    CLR occupies exactly NREGS write cycles.
//  - rd equal to rs1 or rs2 is legal; reads return the pre-write value.
//  - in_* fields are ignored while the handshake is not completed.
//  - Reset mid-CLEAR or with ex_v=1 aborts immediately. No further writes occur.
//    Registers not yet cleared keep their values; the bank itself is reset by the same reset.
// TESTING
//  1. Reset, then LDI r1,0x5A -> next cycle w_r=1, addr_w=1, data_w=0x5A, done=1; then zero=0.
//  2. LDI r2,0x03 then ADD r3,r2,r2 back-to-back -> second write data_w=0x06 (forwarded, not stale rx).
//  3. r4=0xFF, r5=0x01; ADD r6,r4,r5 -> data_w=0x00, zero=1, carry=1.
//     Then SUB r7,r5,r4 -> data_w=0x02, carry=1, zero=0.
//  4. Load r0..r7 with non-zero values, then CLR -> in_ready=0 for 8 cycles.
//     addr_w steps 0..7 with data_w=0; done only at addr_w=7. Then in_ready=1, zero=1, carry=0.
//  5. Hold in_valid with XOR r1,r1,r2 during CLR -> accepted only on the first ready cycle; written exactly once.
//  6. Assert reset while CLEAR has cnt=3 -> next cycle w_r=0, state RUN; in_ready=1 once reset drops.

Source files
------------

// File: rtl/regfile_exec_ctrl.sv
// Execution / write-back sequencer for an 8x8 register bank.
// Takes one instruction per cycle, reads both operands from the bank
// combinationally, holds them in a one-entry EX stage and writes the result
// back on the following edge. A multicycle CLR sweeps zeros through the
// write port.
module regfile_exec_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [DW-1:0] in_imm,
  output logic [AW-1:0] addr_r1,
  output logic [AW-1:0] addr_r2,
  input  logic [DW-1:0] rx,
  input  logic [DW-1:0] ry,
  output logic [AW-1:0] addr_w,
  output logic [DW-1:0] data_w,
  output logic          w_r,
  output logic          done,
  output logic          zero,
  output logic          carry
);

  localparam int NREGS = 2 ** AW;
  localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);

  typedef enum logic [2:0] {
    OP_CLR = 3'd0,
    OP_LDI = 3'd1,
    OP_MOV = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e        state_q;
  logic          ex_v_q;
  op_e           ex_op_q;
  logic [AW-1:0] ex_rd_q;
  logic [DW-1:0] ex_a_q;
  logic [DW-1:0] ex_b_q;
  logic [DW-1:0] ex_imm_q;
  logic [AW-1:0] cnt_q;
  logic          zero_q;
  logic          carry_q;

  logic [DW-1:0] ex_res;
  logic [DW:0]   add_full;
  logic          sub_borrow;
  logic [DW-1:0] op_a_d;
  logic [DW-1:0] op_b_d;
  logic          accept;

  // Handshake and read-port addressing are purely combinational.
  assign in_ready = !reset && (state_q == ST_RUN);
  assign accept   = in_valid && in_ready;
  assign addr_r1  = in_rs1;
  assign addr_r2  = in_rs2;
  assign zero     = zero_q;
  assign carry    = carry_q;

  // A result still sitting in EX has not reached the bank yet, so a
  // dependent instruction must take it directly instead of the stale read.
  assign op_a_d = (ex_v_q && (ex_rd_q == in_rs1)) ? ex_res : rx;
  assign op_b_d = (ex_v_q && (ex_rd_q == in_rs2)) ? ex_res : ry;

  assign add_full   = {1'b0, ex_a_q} + {1'b0, ex_b_q};
  assign sub_borrow = ex_a_q < ex_b_q;

  // EX-stage ALU: result of the captured instruction, modulo 2**DW.
  always_comb begin
    // NOTE: assigning a default first guarantees no latch is inferred.
    ex_res = '0;
    case (ex_op_q)
      OP_LDI:  ex_res = ex_imm_q;
      OP_MOV:  ex_res = ex_a_q;
      OP_ADD:  ex_res = add_full[DW-1:0];
      OP_SUB:  ex_res = ex_a_q - ex_b_q;
      OP_AND:  ex_res = ex_a_q & ex_b_q;
      OP_OR:   ex_res = ex_a_q | ex_b_q;
      OP_XOR:  ex_res = ex_a_q ^ ex_b_q;
      default: ex_res = '0;
    endcase
  end

  // Write-port drive: EX write-back in RUN, zero sweep in CLEAR, silent in reset.
  always_comb begin
    w_r    = 1'b0;
    done   = 1'b0;
    addr_w = '0;
    data_w = '0;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        w_r    = 1'b1;
        addr_w = cnt_q;
        data_w = '0;
        done   = (cnt_q == CNT_LAST);
      end else begin
        w_r    = ex_v_q;
        addr_w = ex_rd_q;
        data_w = ex_res;
        done   = ex_v_q;
      end
    end
  end

  // Sequencer state, EX-stage capture, CLR counter and result flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      ex_v_q   <= 1'b0;
      ex_op_q  <= OP_CLR;
      ex_rd_q  <= '0;
      ex_a_q   <= '0;
      ex_b_q   <= '0;
      ex_imm_q <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      ex_v_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (ex_v_q) begin
            zero_q <= (ex_res == '0);
            if (ex_op_q == OP_ADD) begin
              carry_q <= add_full[DW];
            end else if (ex_op_q == OP_SUB) begin
              carry_q <= sub_borrow;
            end
          end
          if (accept) begin
            if (op_e'(in_op) == OP_CLR) begin
              state_q <= ST_CLEAR;
              cnt_q   <= '0;
            end else begin
              ex_v_q   <= 1'b1;
              ex_op_q  <= op_e'(in_op);
              ex_rd_q  <= in_rd;
              ex_a_q   <= op_a_d;
              ex_b_q   <= op_b_d;
              ex_imm_q <= in_imm;
            end
          end
        end
        ST_CLEAR: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_exec_ctrl.sv
// Bench for regfile_exec_ctrl: a behavioural 8x8 bank feeds the read ports,
// the driver issues directed instructions and queues the expected writes,
// and a negedge monitor pops the queue on every bank write.
module tb_regfile_exec_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;

  localparam logic [2:0] CLR = 3'd0, LDI = 3'd1, MOV = 3'd2, ADD = 3'd3,
                         SUB = 3'd4, ANDI = 3'd5, ORI = 3'd6, XORI = 3'd7;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
    logic          chk_flags;
    logic          z;
    logic          c;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rd, in_rs1, in_rs2;
  logic [DW-1:0] in_imm;
  logic [AW-1:0] addr_r1, addr_r2, addr_w;
  logic [DW-1:0] rx, ry, data_w;
  logic          w_r, done, zero, carry;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [DW-1:0] bank [2**AW];

  regfile_exec_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .addr_r1(addr_r1), .addr_r2(addr_r2), .rx(rx), .ry(ry),
    .addr_w(addr_w), .data_w(data_w), .w_r(w_r),
    .done(done), .zero(zero), .carry(carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model: combinational reads, write at posedge, cleared by reset.
  assign rx = bank[addr_r1];
  assign ry = bank[addr_r2];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**AW; i++) bank[i] <= '0;
    end else if (w_r) begin
      bank[addr_w] <= data_w;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dn,
                       input logic ck, input logic z, input logic c);
    exp_t e;
    e.addr = a; e.data = d; e.done = dn; e.chk_flags = ck; e.z = z; e.c = c;
    sb.push_back(e);
  endtask

  // Called just after a posedge; returns just after the accepting posedge
  // with in_valid still high so instructions can go back-to-back.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [DW-1:0] imm, output int waits);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                     input logic [AW-1:0] rs2, input logic [DW-1:0] imm);
    int w;
    issue(op, rd, rs1, rs2, imm, w);
  endtask

  // Idle cycles with junk on the instruction fields, which must be ignored.
  task automatic idle(input int n);
    in_valid = 1'b0;
    in_op  = 3'($urandom);
    in_rd  = AW'($urandom);
    in_rs1 = AW'($urandom);
    in_rs2 = AW'($urandom);
    in_imm = DW'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every bank write must match the head of the scoreboard; flags
  // are compared one cycle later, after the write-back edge has updated them.
  initial begin
    logic pend;
    logic pz, pc;
    exp_t e;
    pend = 1'b0; pz = 1'b0; pc = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("zero_flag", {31'd0, zero}, {31'd0, pz});
        check("carry_flag", {31'd0, carry}, {31'd0, pc});
        pend = 1'b0;
      end
      if (w_r === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {31'd0, w_r}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("addr_w", {29'd0, addr_w}, {29'd0, e.addr});
          check("data_w", {24'd0, data_w}, {24'd0, e.data});
          check("done", {31'd0, done}, {31'd0, e.done});
          if (e.chk_flags) begin
            pend = 1'b1; pz = e.z; pc = e.c;
          end
        end
      end else if (done !== 1'b0) begin
        check("done_without_write", {31'd0, done}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    int budget;
    reset = 1'b1; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_w_r", {31'd0, w_r}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_addr_w", {29'd0, addr_w}, 32'd0);
    check("rst_data_w", {24'd0, data_w}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_zero", {31'd0, zero}, 32'd0);
    check("post_rst_carry", {31'd0, carry}, 32'd0);
    @(posedge clk);
    #1;

    // LDI r1,0x5A.
    exp_w(3'd1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    ins(LDI, 3'd1, 3'd0, 3'd0, 8'h5A);
    idle(2);

    // Back-to-back dependency: ADD must see the forwarded 0x03.
    exp_w(3'd2, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_w(3'd3, 8'h06, 1'b1, 1'b1, 1'b0, 1'b0);
    ins(LDI, 3'd2, 3'd0, 3'd0, 8'h03);
    ins(ADD, 3'd3, 3'd2, 3'd2, 8'h00);
    idle(2);

    // ADD wraps to zero with carry; SUB borrows.
    exp_w(3'd4, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_w(3'd5, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_w(3'd6, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    exp_w(3'd7, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1);
    ins(LDI, 3'd4, 3'd0, 3'd0, 8'hFF);
    ins(LDI, 3'd5, 3'd0, 3'd0, 8'h01);
    ins(ADD, 3'd6, 3'd4, 3'd5, 8'h00);
    ins(SUB, 3'd7, 3'd5, 3'd4, 8'h00);
    idle(2);

    // Logic ops and MOV keep carry; chained forwarding through r0; rd==rs1.
    exp_w(3'd0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_w(3'd0, 8'h5B, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_w(3'd6, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    exp_w(3'd5, 8'h06, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_w(3'd3, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    ins(ANDI, 3'd0, 3'd1, 3'd4, 8'h00);
    ins(ORI,  3'd0, 3'd0, 3'd2, 8'h00);
    ins(XORI, 3'd6, 3'd0, 3'd0, 8'h00);
    ins(MOV,  3'd5, 3'd3, 3'd0, 8'h00);
    ins(SUB,  3'd3, 3'd3, 3'd2, 8'h00);
    idle(2);

    // All registers non-zero, then CLR right behind the last LDI, with an
    // XOR held valid throughout the sweep.
    exp_w(3'd6, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_w(AW'(i), 8'h00, (i == 7), (i == 7), 1'b1, 1'b0);
    end
    exp_w(3'd1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    ins(LDI, 3'd6, 3'd0, 3'd0, 8'h11);
    issue(CLR, 3'd0, 3'd0, 3'd0, 8'h00, waits);
    check("clr_accept_wait", waits, 32'd0);
    issue(XORI, 3'd1, 3'd1, 3'd2, 8'h00, waits);
    check("clr_busy_cycles", waits, 32'd8);
    idle(4);
    @(negedge clk);
    check("post_clr_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of a CLR sweep (cnt==3).
    exp_w(3'd2, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0);
    ins(LDI, 3'd2, 3'd0, 3'd0, 8'h44);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      exp_w(AW'(i), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    issue(CLR, 3'd0, 3'd0, 3'd0, 8'h00, waits);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_w_r", {31'd0, w_r}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_w_r_after_edge", {31'd0, w_r}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after_reset", {31'd0, in_ready}, 32'd1);
    check("abort_zero", {31'd0, zero}, 32'd0);
    check("abort_carry", {31'd0, carry}, 32'd0);
    check("abort_sb_empty", sb.size(), 32'd0);
    @(posedge clk);
    #1;

    // Back in RUN after the aborted sweep.
    exp_w(3'd7, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    ins(LDI, 3'd7, 3'd0, 3'd0, 8'h80);
    idle(3);

    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    check("sb_drain", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
